// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: writeback has priority, MDU results wait in a FIFO, and a scoreboard stalls decode on RAW hazards.
// Optional macro RF_ARB_BYPASS_EN lets an MDU result drive an idle port in the same cycle without entering the FIFO.
module rf_wport_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_we,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    output logic                      issue_ok,
    input  logic                      mdu_valid,
    output logic                      mdu_ready,
    input  logic [ADDR_W-1:0]         mdu_addr,
    input  logic [DATA_W-1:0]         mdu_data,
    input  logic [ADDR_W-1:0]         rd_addr_1,
    input  logic [ADDR_W-1:0]         rd_addr_2,
    output logic                      stall,
    output logic                      rf_we3,
    output logic [ADDR_W-1:0]         rf_addr_3,
    output logic [DATA_W-1:0]         rf_data_3,
    output logic [$clog2(DEPTH):0]    pend_count
);
    localparam int NREG = 1 << ADDR_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [ADDR_W-1:0] fifoAddr_q [DEPTH];
    logic [DATA_W-1:0] fifoData_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              wbActive;
    logic              fifoEmpty;
    logic              popGo;
    logic              pushGo;
    logic              bypassGo;
    logic              commitGo;
    logic [ADDR_W-1:0] commitAddr;

    assign wbActive  = wb_we && (wb_addr != '0);
    assign fifoEmpty = (count_q == '0);
    assign mdu_ready = (count_q != CW'(DEPTH));
    assign popGo     = !wbActive && !fifoEmpty;
`ifdef RF_ARB_BYPASS_EN
    assign bypassGo  = mdu_valid && fifoEmpty && !wbActive;
`else
    assign bypassGo  = 1'b0;
`endif
    assign pushGo     = mdu_valid && mdu_ready && !bypassGo;
    assign commitGo   = popGo || bypassGo;
    assign commitAddr = popGo ? fifoAddr_q[rdPtr_q] : mdu_addr;

    assign issue_ok   = !busy_q[issue_addr];
    assign stall      = ((rd_addr_1 != '0) && busy_q[rd_addr_1]) ||
                        ((rd_addr_2 != '0) && busy_q[rd_addr_2]);
    assign pend_count = count_q;

    always_comb begin
        rf_we3    = 1'b0;
        rf_addr_3 = '0;
        rf_data_3 = '0;
        if (wbActive) begin
            rf_we3    = 1'b1;
            rf_addr_3 = wb_addr;
            rf_data_3 = wb_data;
        end else if (popGo) begin
            rf_we3    = 1'b1;
            rf_addr_3 = fifoAddr_q[rdPtr_q];
            rf_data_3 = fifoData_q[rdPtr_q];
        end else if (bypassGo) begin
            rf_we3    = 1'b1;
            rf_addr_3 = mdu_addr;
            rf_data_3 = mdu_data;
        end
    end

    // A new reservation is applied after the commit clear so that set wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (commitGo)
            busy_d[commitAddr] = 1'b0;
        if (issue_valid && issue_ok)
            busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wrPtr_d = pushGo ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = popGo  ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d = count_q;
        if (pushGo && !popGo)
            count_d = count_q + CW'(1);
        else if (popGo && !pushGo)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    // Entry storage needs no reset; only the pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (pushGo) begin
            fifoAddr_q[wrPtr_q] <= mdu_addr;
            fifoData_q[wrPtr_q] <= mdu_data;
        end
    end
endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: a port monitor checks every register-file write against queues of expected writes.
// Latency-dependent checks follow RF_ARB_BYPASS_EN when the bench is built with it.
module tb_rf_wport_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ok;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [4:0]  rd_addr_1;
    logic [4:0]  rd_addr_2;
    logic        stall;
    logic        rf_we3;
    logic [4:0]  rf_addr_3;
    logic [31:0] rf_data_3;
    logic [1:0]  pend_count;

    int assertCount = 0;
    int failCount   = 0;
    logic [63:0] wbQ[$];
    logic [63:0] mduQ[$];

    rf_wport_arb #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ok(issue_ok),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .stall(stall),
        .rf_we3(rf_we3), .rf_addr_3(rf_addr_3), .rf_data_3(rf_data_3),
        .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, record the writes they must cause, then wait for the sampling edge.
    task automatic applyStimulus(input logic wbWe, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                 input logic mduV, input logic [4:0] mduA, input logic [31:0] mduD,
                                 input logic expectMdu, input logic issV, input logic [4:0] issA,
                                 input logic [4:0] r1, input logic [4:0] r2);
        wb_we = wbWe; wb_addr = wbAddr; wb_data = wbData;
        mdu_valid = mduV; mdu_addr = mduA; mdu_data = mduD;
        issue_valid = issV; issue_addr = issA;
        rd_addr_1 = r1; rd_addr_2 = r2;
        if (!reset && wbWe && wbAddr != 5'd0)
            wbQ.push_back({27'd0, wbAddr, wbData});
        if (expectMdu)
            mduQ.push_back({27'd0, mduA, mduD});
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] issA, input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, issA, r1, r2);
    endtask

    // Port monitor: writeback owns the port whenever it targets a nonzero register, otherwise MDU results drain in order.
    always @(negedge clk) begin
        if (reset === 1'b0 && rf_we3 === 1'b1) begin
            if (wb_we && wb_addr != 5'd0) begin
                if (wbQ.size() == 0) checkOutput("wb_write_unexpected", 64'd1, 64'd0);
                else checkOutput("wb_write", {27'd0, rf_addr_3, rf_data_3}, wbQ.pop_front());
            end else begin
                if (mduQ.size() == 0) checkOutput("mdu_write_unexpected", {27'd0, rf_addr_3, rf_data_3}, 64'd0);
                else checkOutput("mdu_write", {27'd0, rf_addr_3, rf_data_3}, mduQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        wb_we = 0; wb_addr = 0; wb_data = 0; issue_valid = 0; issue_addr = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; rd_addr_1 = 0; rd_addr_2 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        idle(5'd0, 5'd0, 5'd0);
        checkOutput("rst_pend", pend_count, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_ready", mdu_ready, 1);
        checkOutput("rst_issue_ok", issue_ok, 1);
        checkOutput("rst_we3", rf_we3, 0);
        advance();

        // Reserve r5 and observe the hazard
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
        checkOutput("iss5_ok", issue_ok, 1);
        advance();
        idle(5'd5, 5'd5, 5'd0);
        checkOutput("stall_r5", stall, 1);
        checkOutput("iss5_busy", issue_ok, 0);
        advance();
        idle(5'd0, 5'd0, 5'd0);
        checkOutput("nostall_r0", stall, 0);
        advance();

        // MDU result for r5
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 0, 0, 5'd5, 0);
`ifdef RF_ARB_BYPASS_EN
        checkOutput("t2_we3_bypass", rf_we3, 1);
`else
        checkOutput("t2_we3_push", rf_we3, 0);
`endif
        checkOutput("t2_stall_pre", stall, 1);
        checkOutput("t2_pend0", pend_count, 0);
        advance();
        idle(0, 5'd5, 0);
`ifdef RF_ARB_BYPASS_EN
        checkOutput("t2_stall_byp", stall, 0);
        checkOutput("t2_we3_idle", rf_we3, 0);
`else
        checkOutput("t2_we3_commit", rf_we3, 1);
        checkOutput("t2_addr_commit", rf_addr_3, 5);
        checkOutput("t2_pend1", pend_count, 1);
        checkOutput("t2_stall_hold", stall, 1);
`endif
        advance();
        idle(0, 5'd5, 0);
        checkOutput("t2_stall_clr", stall, 0);
        checkOutput("t2_pend_clr", pend_count, 0);
        checkOutput("t2_we3_off", rf_we3, 0);
        advance();

        // WB busy for 4 cycles while MDU results arrive
        applyStimulus(1, 5'd1, 32'd100, 1, 5'd12, 32'hA, 1, 0, 0, 0, 0);
        checkOutput("t3a_ready", mdu_ready, 1);
        checkOutput("t3a_pend", pend_count, 0);
        advance();
        applyStimulus(1, 5'd2, 32'd200, 1, 5'd13, 32'hB, 1, 0, 0, 0, 0);
        checkOutput("t3b_pend", pend_count, 1);
        advance();
        applyStimulus(1, 5'd3, 32'd300, 1, 5'd14, 32'hC, 0, 0, 0, 0, 0);
        checkOutput("t3c_pend", pend_count, 2);
        checkOutput("t3c_ready", mdu_ready, 0);
        advance();
        applyStimulus(1, 5'd4, 32'd400, 1, 5'd14, 32'hC, 0, 0, 0, 0, 0);
        checkOutput("t3d_ready", mdu_ready, 0);
        checkOutput("t3d_addr", rf_addr_3, 4);
        advance();
        applyStimulus(0, 0, 0, 1, 5'd14, 32'hC, 0, 0, 0, 0, 0);
        checkOutput("t3e_ready_full", mdu_ready, 0);
        checkOutput("t3e_addr", rf_addr_3, 12);
        advance();
        applyStimulus(0, 0, 0, 1, 5'd14, 32'hC, 1, 0, 0, 0, 0);
        checkOutput("t3f_ready", mdu_ready, 1);
        checkOutput("t3f_pend", pend_count, 1);
        checkOutput("t3f_addr", rf_addr_3, 13);
        advance();
        idle(0, 0, 0);
        checkOutput("t3g_pend", pend_count, 1);
        checkOutput("t3g_addr", rf_addr_3, 14);
        advance();
        idle(0, 0, 0);
        checkOutput("t3h_pend", pend_count, 0);
        checkOutput("t3h_we3", rf_we3, 0);
        advance();

        // WB write to r0 leaves the port to the FIFO; issue to r0 reserves nothing
        applyStimulus(1, 5'd1, 32'h111, 1, 5'd7, 32'h777, 1, 0, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd0, 32'h55, 0, 0, 0, 0, 1, 5'd0, 0, 0);
        checkOutput("t4_we3", rf_we3, 1);
        checkOutput("t4_addr", rf_addr_3, 7);
        checkOutput("t4_data", rf_data_3, 32'h777);
        checkOutput("t4_iss0_ok", issue_ok, 1);
        advance();
        idle(5'd0, 5'd0, 5'd0);
        checkOutput("t4_stall0", stall, 0);
        checkOutput("t4_iss0_again", issue_ok, 1);
        checkOutput("t4_pend", pend_count, 0);
        advance();

        // Re-issue to busy r9 is refused; set wins over a same-cycle commit
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
        checkOutput("t5_iss9", issue_ok, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
        checkOutput("t5_iss9_refused", issue_ok, 0);
        checkOutput("t5_stall9", stall, 1);
        advance();
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 1, 0, 5'd9, 0, 5'd9);
        advance();
        idle(5'd9, 0, 5'd9);
        advance();
`ifdef RF_ARB_BYPASS_EN
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h98, 1, 1, 5'd9, 0, 5'd9);
`else
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h98, 1, 0, 5'd9, 0, 5'd9);
`endif
        checkOutput("t5_single_resv", stall, 0);
        checkOutput("t5_iss9_free", issue_ok, 1);
        advance();
`ifdef RF_ARB_BYPASS_EN
        idle(5'd9, 0, 5'd9);
`else
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
        checkOutput("t5_commit9", rf_addr_3, 9);
        checkOutput("t5_iss_with_commit", issue_ok, 1);
`endif
        advance();
        idle(5'd9, 0, 5'd9);
        checkOutput("t5_set_wins_stall", stall, 1);
        checkOutput("t5_set_wins_busy", issue_ok, 0);
        advance();

        // Reset with a full FIFO discards the buffered results and reservations
        applyStimulus(1, 5'd1, 32'h1000, 1, 5'd20, 32'h2020, 0, 0, 0, 0, 0);
        advance();
        applyStimulus(1, 5'd2, 32'h2000, 1, 5'd21, 32'h2121, 0, 0, 0, 0, 0);
        checkOutput("t6_pend1", pend_count, 1);
        advance();
        reset = 1'b1;
        applyStimulus(1, 5'd3, 32'h3000, 0, 0, 0, 0, 0, 5'd9, 0, 5'd9);
        checkOutput("t6_pend2", pend_count, 2);
        checkOutput("t6_stall_pre", stall, 1);
        advance();
        reset = 1'b0;
        idle(5'd9, 0, 5'd9);
        checkOutput("t6_pend_rst", pend_count, 0);
        checkOutput("t6_we3_rst", rf_we3, 0);
        checkOutput("t6_stall_rst", stall, 0);
        checkOutput("t6_ready_rst", mdu_ready, 1);
        checkOutput("t6_issue_rst", issue_ok, 1);
        advance();
        idle(0, 0, 0);
        checkOutput("t6_we3_after", rf_we3, 0);
        advance();

        // Idle-port MDU result: same-cycle write with bypass, one cycle later without
        applyStimulus(0, 0, 0, 1, 5'd6, 32'h66, 1, 0, 0, 0, 0);
        checkOutput("t7_pend", pend_count, 0);
`ifdef RF_ARB_BYPASS_EN
        checkOutput("t7_we3_same", rf_we3, 1);
        checkOutput("t7_addr_same", rf_addr_3, 6);
`else
        checkOutput("t7_we3_same", rf_we3, 0);
`endif
        advance();
        idle(0, 0, 0);
`ifdef RF_ARB_BYPASS_EN
        checkOutput("t7_we3_next", rf_we3, 0);
`else
        checkOutput("t7_we3_next", rf_we3, 1);
        checkOutput("t7_addr_next", rf_addr_3, 6);
`endif
        advance();
        idle(0, 0, 0);
        advance();

        checkOutput("wb_queue_drained", wbQ.size(), 0);
        checkOutput("mdu_queue_drained", mduQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
